// File: rtl/gift_pkg.sv
// Shared types and helpers for the iterative GIFT control path.
// The round-index helper is shared by the controller and any datapath that needs the same mapping.
package gift_pkg;

  localparam int GIFT64_ROUNDS  = 28;
  localparam int GIFT128_ROUNDS = 40;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateE;

  // Index of the first round computed in an iteration.
  // Decryption walks the schedule backwards, starting at the last unrolled group.
  function automatic int calcRoundIdx(input int cnt, input logic decrypt,
                                      input int unroll, input int rounds);
    if (decrypt) return rounds - unroll - cnt * unroll;
    return cnt * unroll;
  endfunction

endpackage

// File: rtl/gift_iter_ctrl.sv
// Control FSM for an iterative GIFT datapath.
// Sequences key/data loading, round feedback, round indexing and the handshake of the data-out register.
//
// state | meaning
// IDLE  | waiting; external key/data writes pass straight through
// RUN   | iterating; round register fed back, counter advancing
// DONE  | result held in data-out register until the consumer takes it
module gift_iter_ctrl
  import gift_pkg::*;
#(
  parameter int ROUNDS = GIFT64_ROUNDS,
  parameter int UNROLL = 1,
  localparam int ITER  = ROUNDS / UNROLL,
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1,
  localparam int IDX_W = $clog2(ROUNDS)
) (
  input  logic             inClk,
  input  logic             inRstN,
  input  logic             inExtKeyWr,
  input  logic             inExtDataWr,
  input  logic             inDecrypt,
  input  logic             inOutReady,
  output logic             outIntKeyschRegExtWr,
  output logic             outIntRoundRegExtWr,
  output logic             outIntRoundRegFbWr,
  output logic             outIntDataOutRegWr,
  output logic [IDX_W-1:0] outRoundIdx,
  output logic             outDecrypt,
  output logic             outBusy,
  output logic             outValid
);

  if (UNROLL < 1 || (ROUNDS % UNROLL) != 0) begin : gBadUnroll
    $error("gift_iter_ctrl: UNROLL must divide ROUNDS");
  end

  stateE            state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             mode, modeNext;
  logic             lastIter;
  logic             keyWr, roundExtWr;

  assign lastIter = (cnt == CNT_W'(ITER - 1));

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state <= IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
      mode  <= modeNext;
    end
  end

  always_comb begin
    stateNext          = state;
    cntNext            = cnt;
    modeNext           = mode;
    keyWr              = 1'b0;
    roundExtWr         = 1'b0;
    outIntRoundRegFbWr = 1'b0;
    outIntDataOutRegWr = 1'b0;
    outRoundIdx        = '0;
    outBusy            = 1'b0;
    outValid           = 1'b0;
    case (state)
      IDLE: begin
        keyWr      = inExtKeyWr;
        roundExtWr = inExtDataWr;
        if (inExtDataWr) begin
          modeNext  = inDecrypt;
          cntNext   = '0;
          stateNext = RUN;
        end
      end
      RUN: begin
        outBusy            = 1'b1;
        outIntRoundRegFbWr = 1'b1;
        outRoundIdx        = IDX_W'(calcRoundIdx(int'(cnt), mode, UNROLL, ROUNDS));
        if (lastIter) begin
          outIntDataOutRegWr = 1'b1;
          cntNext            = '0;
          stateNext          = DONE;
        end else begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        outValid = 1'b1;
        keyWr    = inExtKeyWr;
        // A start is only honoured together with the consumer taking the result.
        if (inOutReady) begin
          if (inExtDataWr) begin
            roundExtWr = 1'b1;
            modeNext   = inDecrypt;
            cntNext    = '0;
            stateNext  = RUN;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Pass-through strobes are forced low while reset is asserted.
  assign outIntKeyschRegExtWr = keyWr & inRstN;
  assign outIntRoundRegExtWr  = roundExtWr & inRstN;
  assign outDecrypt           = mode;

endmodule

// File: tb/tb_gift_iter_ctrl.sv
// Directed bench for gift_iter_ctrl: three instances (GIFT-64 x1, GIFT-128 x4, GIFT-64 fully unrolled)
// share one stimulus bus; each scenario resets and checks the instance it targets.
module tb_gift_iter_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstN = 1'b0, keyWr = 1'b0, dataWr = 1'b0, decrypt = 1'b0, outReady = 1'b0;

  logic aKs, aRe, aFb, aDo, aDec, aBusy, aValid;
  logic [4:0] aIdx;
  logic bKs, bRe, bFb, bDo, bDec, bBusy, bValid;
  logic [5:0] bIdx;
  logic cKs, cRe, cFb, cDo, cDec, cBusy, cValid;
  logic [4:0] cIdx;

  gift_iter_ctrl #(.ROUNDS(28), .UNROLL(1)) dutA (
    .inClk(clk), .inRstN(rstN), .inExtKeyWr(keyWr), .inExtDataWr(dataWr),
    .inDecrypt(decrypt), .inOutReady(outReady),
    .outIntKeyschRegExtWr(aKs), .outIntRoundRegExtWr(aRe), .outIntRoundRegFbWr(aFb),
    .outIntDataOutRegWr(aDo), .outRoundIdx(aIdx), .outDecrypt(aDec),
    .outBusy(aBusy), .outValid(aValid));

  gift_iter_ctrl #(.ROUNDS(40), .UNROLL(4)) dutB (
    .inClk(clk), .inRstN(rstN), .inExtKeyWr(keyWr), .inExtDataWr(dataWr),
    .inDecrypt(decrypt), .inOutReady(outReady),
    .outIntKeyschRegExtWr(bKs), .outIntRoundRegExtWr(bRe), .outIntRoundRegFbWr(bFb),
    .outIntDataOutRegWr(bDo), .outRoundIdx(bIdx), .outDecrypt(bDec),
    .outBusy(bBusy), .outValid(bValid));

  gift_iter_ctrl #(.ROUNDS(28), .UNROLL(28)) dutC (
    .inClk(clk), .inRstN(rstN), .inExtKeyWr(keyWr), .inExtDataWr(dataWr),
    .inDecrypt(decrypt), .inOutReady(outReady),
    .outIntKeyschRegExtWr(cKs), .outIntRoundRegExtWr(cRe), .outIntRoundRegFbWr(cFb),
    .outIntDataOutRegWr(cDo), .outRoundIdx(cIdx), .outDecrypt(cDec),
    .outBusy(cBusy), .outValid(cValid));

  // Observation word: {keysch, roundExt, roundFb, dataOut, busy, valid, decrypt, idx[5:0]}
  logic [12:0] obsA, obsB, obsC;
  assign obsA = {aKs, aRe, aFb, aDo, aBusy, aValid, aDec, 1'b0, aIdx};
  assign obsB = {bKs, bRe, bFb, bDo, bBusy, bValid, bDec, bIdx};
  assign obsC = {cKs, cRe, cFb, cDo, cBusy, cValid, cDec, 1'b0, cIdx};

  int errors = 0;
  int checks = 0;

  function automatic logic [12:0] pack(input logic k, r, f, d, b, v, m, input int idx);
    return {k, r, f, d, b, v, m, 6'(idx)};
  endfunction

  // Apply inputs just after a falling edge and settle; outputs are then checked mid-cycle.
  task automatic drive(input logic k, input logic d, input logic m, input logic rdy);
    @(negedge clk);
    keyWr = k; dataWr = d; decrypt = m; outReady = rdy;
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0; keyWr = 1'b0; dataWr = 1'b0; decrypt = 1'b0; outReady = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstN = 1'b0; keyWr = 1'b1; dataWr = 1'b1; decrypt = 1'b1; outReady = 1'b1;
    #1;
    checks++; if (obsA !== 13'd0) begin errors++; $display("FAIL reset_hold_a got=%b exp=%b", obsA, 13'd0); end
    checks++; if (obsB !== 13'd0) begin errors++; $display("FAIL reset_hold_b got=%b exp=%b", obsB, 13'd0); end
    checks++; if (obsC !== 13'd0) begin errors++; $display("FAIL reset_hold_c got=%b exp=%b", obsC, 13'd0); end
    @(negedge clk);
    rstN = 1'b1; keyWr = 1'b0; dataWr = 1'b0; decrypt = 1'b0; outReady = 1'b0;
    #1;
    checks++; if (obsA !== 13'd0) begin errors++; $display("FAIL reset_rel_a got=%b exp=%b", obsA, 13'd0); end
    checks++; if (obsB !== 13'd0) begin errors++; $display("FAIL reset_rel_b got=%b exp=%b", obsB, 13'd0); end
    checks++; if (obsC !== 13'd0) begin errors++; $display("FAIL reset_rel_c got=%b exp=%b", obsC, 13'd0); end
  endtask

  // Start at cycle 10: busy 11..38, idx 0..27, data-out write at 38, valid at 39, idle at 40.
  task automatic test_enc28();
    logic [12:0] exp;
    doReset();
    for (int c = 0; c <= 41; c++) begin
      drive(1'b0, c == 10, 1'b0, 1'b1);
      if (c == 10)                exp = pack(0, 1, 0, 0, 0, 0, 0, 0);
      else if (c >= 11 && c <= 38) exp = pack(0, 0, 1, c == 38, 1, 0, 0, c - 11);
      else if (c == 39)           exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
      else                        exp = pack(0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if (obsA !== exp) begin errors++; $display("FAIL enc28 cyc=%0d got=%b exp=%b", c, obsA, exp); end
    end
  endtask

  task automatic test_dec40();
    logic [12:0] exp;
    doReset();
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    exp = pack(0, 1, 0, 0, 0, 0, 0, 0);
    if (obsB !== exp) begin errors++; $display("FAIL dec40_start got=%b exp=%b", obsB, exp); end
    for (int k = 0; k < 10; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      exp = pack(0, 0, 1, k == 9, 1, 0, 1, 36 - 4 * k);
      checks++;
      if (obsB !== exp) begin errors++; $display("FAIL dec40 k=%0d got=%b exp=%b", k, obsB, exp); end
    end
  endtask

  // Continues from test_dec40 with dutB in DONE.
  task automatic test_back_to_back();
    logic [12:0] exp;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, i == 2, 1'b0, 1'b0);
      exp = pack(0, 0, 0, 0, 0, 1, 1, 0);
      checks++;
      if (obsB !== exp) begin errors++; $display("FAIL done_hold i=%0d got=%b exp=%b", i, obsB, exp); end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    exp = pack(0, 1, 0, 0, 0, 1, 1, 0);
    checks++;
    if (obsB !== exp) begin errors++; $display("FAIL b2b_handover got=%b exp=%b", obsB, exp); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp = pack(0, 0, 1, 0, 1, 0, 0, 0);
    checks++;
    if (obsB !== exp) begin errors++; $display("FAIL b2b_run0 got=%b exp=%b", obsB, exp); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp = pack(0, 0, 1, 0, 1, 0, 0, 4);
    checks++;
    if (obsB !== exp) begin errors++; $display("FAIL b2b_run1 got=%b exp=%b", obsB, exp); end
  endtask

  task automatic test_run_writes();
    logic [12:0] exp;
    doReset();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 28; k++) begin
      drive(k == 14, k == 14, k == 14, 1'b1);
      exp = pack(0, 0, 1, k == 27, 1, 0, 0, k);
      checks++;
      if (obsA !== exp) begin errors++; $display("FAIL run_writes k=%0d got=%b exp=%b", k, obsA, exp); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (obsA !== exp) begin errors++; $display("FAIL run_writes_done got=%b exp=%b", obsA, exp); end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    exp = pack(1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obsA !== exp) begin errors++; $display("FAIL idle_keywr got=%b exp=%b", obsA, exp); end
  endtask

  task automatic test_reset_abort();
    logic [12:0] exp;
    doReset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp = pack(0, 0, 1, 0, 1, 0, 0, 19);
    checks++;
    if (obsA !== exp) begin errors++; $display("FAIL abort_pre_a got=%b exp=%b", obsA, exp); end
    exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (obsB !== exp) begin errors++; $display("FAIL abort_pre_b got=%b exp=%b", obsB, exp); end
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checks++; if (obsA !== 13'd0) begin errors++; $display("FAIL abort_a got=%b exp=%b", obsA, 13'd0); end
    checks++; if (obsB !== 13'd0) begin errors++; $display("FAIL abort_b got=%b exp=%b", obsB, 13'd0); end
    @(negedge clk);
    rstN = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp = pack(0, 0, 1, 0, 1, 0, 1, 27);
    checks++;
    if (obsA !== exp) begin errors++; $display("FAIL restart0 got=%b exp=%b", obsA, exp); end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    exp = pack(0, 0, 1, 0, 1, 0, 1, 26);
    checks++;
    if (obsA !== exp) begin errors++; $display("FAIL restart1 got=%b exp=%b", obsA, exp); end
  endtask

  task automatic test_iter1();
    logic [12:0] exp;
    doReset();
    drive(1'b0, 1'b1, 1'b0, 1'b1);
    exp = pack(0, 1, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obsC !== exp) begin errors++; $display("FAIL iter1_start got=%b exp=%b", obsC, exp); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = pack(0, 0, 1, 1, 1, 0, 0, 0);
    checks++;
    if (obsC !== exp) begin errors++; $display("FAIL iter1_run got=%b exp=%b", obsC, exp); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = pack(0, 0, 0, 0, 0, 1, 0, 0);
    checks++;
    if (obsC !== exp) begin errors++; $display("FAIL iter1_done got=%b exp=%b", obsC, exp); end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    exp = pack(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (obsC !== exp) begin errors++; $display("FAIL iter1_idle got=%b exp=%b", obsC, exp); end
  endtask

  initial begin
    test_reset();
    test_enc28();
    test_dec40();
    test_back_to_back();
    test_run_writes();
    test_reset_abort();
    test_iter1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gift_iter_ctrl.md
Name: gift_iter_ctrl

Overview:
- Parametrised control FSM for an iterative GIFT datapath (GIFT-64 or GIFT-128) that processes UNROLL rounds per clock.
- Sequences loading of external key and data, feedback iterations through the round register, round-constant indexing, encrypt/decrypt direction, and the output-register write.
- Adds an output valid/ready handshake with back-to-back start.
- Sits between the external bus interface and the round/keyschedule/data-out registers.

Parameters:
- ROUNDS, 28, total cipher rounds (28 = GIFT-64, 40 = GIFT-128).
- UNROLL, 1, rounds per clock; must divide ROUNDS; elaboration error otherwise.
- ITER, ROUNDS/UNROLL, derived (localparam): iterations per block.
- CNT_W, $clog2(ITER) (min 1), derived: iteration counter width.
- IDX_W, $clog2(ROUNDS), derived: round index width.

Ports:
- inClk  in  1  clock, rising edge.
- inRstN  in  1  asynchronous active-low reset.
- inExtKeyWr  in  1  external key write request.
- inExtDataWr  in  1  external data write / start request.
- inDecrypt  in  1  mode for the block started this cycle (0 enc, 1 dec).
- inOutReady  in  1  consumer accepts the result.
- outIntKeyschRegExtWr  out  1  load keyschedule register from external bus.
- outIntRoundRegExtWr  out  1  load round register from external bus.
- outIntRoundRegFbWr  out  1  load round register from round-function output.
- outIntDataOutRegWr  out  1  capture final state into data-out register.
- outRoundIdx  out  IDX_W  index of first round computed this cycle.
- outDecrypt  out  1  latched mode of the block in flight.
- outBusy  out  1  iteration in progress.
- outValid  out  1  data-out register holds an unconsumed result.

Behaviour:
- States: IDLE, RUN, DONE. Registers: state, cnt (CNT_W), mode.
- Reset (async, inRstN=0): state=IDLE, cnt=0, mode=0. All outputs 0 while in reset and immediately after. Reset mid-RUN or mid-DONE aborts; the result is discarded and outValid drops asynchronously.
- IDLE:
  - outIntKeyschRegExtWr = inExtKeyWr and outIntRoundRegExtWr = inExtDataWr (combinational).
  - On inExtDataWr=1: mode<=inDecrypt, cnt<=0, state<=RUN.
  - Key and data write in the same cycle are both passed.
- RUN:
  - outBusy=1, outIntRoundRegFbWr=1.
  - External key/data writes are ignored (gated to 0, no effect).
  - cnt increments each cycle.
  - When cnt==ITER-1: outIntDataOutRegWr=1, cnt<=0, state<=DONE.
  - Latency: start at cycle t gives outIntDataOutRegWr at t+ITER and outValid from t+ITER+1.
- outRoundIdx:
  - enc: cnt*UNROLL.
  - dec: ROUNDS-UNROLL-cnt*UNROLL.
  - 0 outside RUN.
  - Arithmetic is in IDX_W bits; no wrap within legal parameter range.
- outDecrypt = mode (registered, stable through RUN and DONE).
- DONE:
  - outValid=1, outBusy=0. Key write passes through as in IDLE.
  - inOutReady=0: hold DONE; outValid stays 1; a data write is ignored.
  - inOutReady=1, inExtDataWr=0: state<=IDLE.
  - inOutReady=1, inExtDataWr=1: result consumed and new block starts the same cycle. outIntRoundRegExtWr=1, mode<=inDecrypt, state<=RUN (back-to-back, no bubble).
- ITER=1: RUN lasts exactly one cycle, with outIntDataOutRegWr in that cycle.
- No output asserts X; outIntRoundRegExtWr and outIntRoundRegFbWr are never both 1.

Decomposition:
- Shared package gift_pkg holds:
  - state enum.
  - GIFT64_ROUNDS=28 and GIFT128_ROUNDS=40.
  - A function that computes the round index from cnt, mode and UNROLL.
- Single module, no sub-modules; the FSM and counter are small enough to stay flat.

Test Plan:
- ROUNDS=28, UNROLL=1, enc, inOutReady=1, start at cycle 10 -> outIntRoundRegExtWr at 10; outBusy for cycles 11-38; outRoundIdx 0..27; outIntDataOutRegWr at 38; outValid at 39; IDLE at 40.
- ROUNDS=40, UNROLL=4, dec -> 10 RUN cycles; outRoundIdx 36,32,...,0; outDecrypt=1 throughout; outIntDataOutRegWr on the 10th RUN cycle.
- DONE with inOutReady=0 for 5 cycles plus a data write -> outValid held and the write ignored. Then ready=1 with a data write the same cycle -> new RUN starts next cycle with outIntRoundRegExtWr=1 in the handover cycle.
- Key and data writes during RUN (cycle 15 of 28) -> both internal write strobes stay 0 and cnt/idx are unaffected. Key write in IDLE -> outIntKeyschRegExtWr=1 in the same cycle.
- inRstN low at cycle 20 of RUN -> outBusy=0, outValid=0, outRoundIdx=0 asynchronously; after release, a data write starts cleanly from cnt=0.
- ROUNDS=28, UNROLL=28 (ITER=1) -> single RUN cycle with outRoundIdx=0 and outIntDataOutRegWr=1, then DONE.
